// File: rtl/proc_pkg.sv
// Shared types for the parametrised multi-cycle processor:
// opcode and FSM state encodings, and the internal bus source select.
package proc_pkg;

    localparam int OPW = 3;  // opcode field width at the top of the instruction word

    typedef enum logic [2:0] {
        MV   = 3'b000,
        MVI  = 3'b001,
        ADD  = 3'b010,
        SUB  = 3'b011,
        LD   = 3'b100,
        ST   = 3'b101,
        MVNZ = 3'b110,
        RSVD = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        T1,
        T2,
        T3
    } state_t;

    // Exactly one bus driver per cycle; SEL_NONE parks the bus at zero.
    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RX,
        SEL_RY,
        SEL_DIN,
        SEL_G
    } bus_sel_t;

endpackage

// File: rtl/proc_reg.sv
// Enable-loaded register, async active-high clear to zero.
module proc_reg #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Load D when enabled; reset wins asynchronously.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) Q <= '0;
        else if (En) Q <= D;
    end

endmodule

// File: rtl/param_processor.sv
// Multi-cycle processor core: mv/mvi/add/sub/ld/st/mvnz with a Run/Done
// handshake and a data-memory port (ADDR/DOUT/W, read data on DIN).
// Optional macro PROC_FLAGS_EN adds a Flags[2:0] = {Z, N, C} output.
module param_processor
    import proc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Run,
    input  logic [WIDTH-1:0] DIN,
    output logic             Done,
    output logic [WIDTH-1:0] BUS,
    output logic [WIDTH-1:0] ADDR,
    output logic [WIDTH-1:0] DOUT,
`ifdef PROC_FLAGS_EN
    output logic [2:0]       Flags,
`endif
    output logic             W
);

    localparam int RBITS = $clog2(NREGS);

    state_t           state_q, state_d;
    bus_sel_t         bus_sel;
    logic [WIDTH-1:0] ir_q, a_q, g_q;
    logic [WIDTH-1:0] r_q [NREGS];
    logic             ir_en, a_en, g_en, addr_en, dout_en, rx_en;
    logic             z_q, is_sub;
    logic [WIDTH:0]   alu;
    logic             unused_bits;
    opcode_t          op;
    logic [RBITS-1:0] rx, ry;

    assign op = opcode_t'(ir_q[WIDTH-1 -: OPW]);
    assign rx = ir_q[WIDTH-1-OPW -: RBITS];
    assign ry = ir_q[WIDTH-1-OPW-RBITS -: RBITS];

    // Instruction LSBs past Ry and the ALU carry (flags-off build) are don't-care.
    assign unused_bits = ^{ir_q, alu};

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state, datapath enables, bus select, Done and W decode.
    always_comb begin
        state_d = state_q;
        bus_sel = SEL_NONE;
        ir_en   = 1'b0;
        a_en    = 1'b0;
        g_en    = 1'b0;
        addr_en = 1'b0;
        dout_en = 1'b0;
        rx_en   = 1'b0;
        Done    = 1'b0;
        W       = 1'b0;
        case (state_q)
            IDLE: if (Run) begin
                ir_en   = 1'b1;
                state_d = T1;
            end
            T1: begin
                state_d = IDLE;
                case (op)
                    MV:      begin bus_sel = SEL_RY;  rx_en = 1'b1; Done = 1'b1; end
                    MVI:     begin bus_sel = SEL_DIN; rx_en = 1'b1; Done = 1'b1; end
                    ADD,
                    SUB:     begin bus_sel = SEL_RX;  a_en = 1'b1; state_d = T2; end
                    LD:      begin bus_sel = SEL_RY;  addr_en = 1'b1; state_d = T2; end
                    ST:      begin bus_sel = SEL_RY;  addr_en = 1'b1; dout_en = 1'b1; state_d = T2; end
                    MVNZ:    begin bus_sel = SEL_RY;  rx_en = ~z_q; Done = 1'b1; end
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                state_d = IDLE;
                case (op)
                    ADD, SUB: begin bus_sel = SEL_RY; g_en = 1'b1; state_d = T3; end
                    LD:       state_d = T3;  // RAM read latency
                    ST:       begin W = 1'b1; Done = 1'b1; end
                    default:  state_d = IDLE;
                endcase
            end
            T3: begin
                state_d = IDLE;
                case (op)
                    ADD, SUB: begin bus_sel = SEL_G;   rx_en = 1'b1; Done = 1'b1; end
                    LD:       begin bus_sel = SEL_DIN; rx_en = 1'b1; Done = 1'b1; end
                    default:  state_d = IDLE;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // Internal bus multiplexer.
    always_comb begin
        case (bus_sel)
            SEL_RX:  BUS = r_q[rx];
            SEL_RY:  BUS = r_q[ry];
            SEL_DIN: BUS = DIN;
            SEL_G:   BUS = g_q;
            default: BUS = '0;
        endcase
    end

    // Subtract as A + ~B + 1 so the carry-out is the NOT-borrow.
    assign is_sub = (op == SUB);
    assign alu    = {1'b0, a_q} + {1'b0, (is_sub ? ~BUS : BUS)} + {{WIDTH{1'b0}}, is_sub};

    proc_reg #(.WIDTH(WIDTH)) u_ir   (.Clock(Clock), .Reset(Reset), .En(ir_en),   .D(DIN),              .Q(ir_q));
    proc_reg #(.WIDTH(WIDTH)) u_a    (.Clock(Clock), .Reset(Reset), .En(a_en),    .D(BUS),              .Q(a_q));
    proc_reg #(.WIDTH(WIDTH)) u_g    (.Clock(Clock), .Reset(Reset), .En(g_en),    .D(alu[WIDTH-1:0]),   .Q(g_q));
    proc_reg #(.WIDTH(WIDTH)) u_addr (.Clock(Clock), .Reset(Reset), .En(addr_en), .D(BUS),              .Q(ADDR));
    proc_reg #(.WIDTH(WIDTH)) u_dout (.Clock(Clock), .Reset(Reset), .En(dout_en), .D(r_q[rx]),          .Q(DOUT));

    for (genvar k = 0; k < NREGS; k++) begin : g_regs
        proc_reg #(.WIDTH(WIDTH)) u_r (
            .Clock(Clock),
            .Reset(Reset),
            .En   (rx_en && (rx == RBITS'(k))),
            .D    (BUS),
            .Q    (r_q[k])
        );
    end

    // Zero flag, updated only when G captures an add/sub result.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)     z_q <= 1'b0;
        else if (g_en) z_q <= (alu[WIDTH-1:0] == '0);
    end

`ifdef PROC_FLAGS_EN
    logic n_q, c_q;

    // Sign and carry flags, captured alongside Z.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            n_q <= 1'b0;
            c_q <= 1'b0;
        end else if (g_en) begin
            n_q <= alu[WIDTH-1];
            c_q <= alu[WIDTH];
        end
    end

    assign Flags = {z_q, n_q, c_q};
`endif

endmodule

// File: tb/tb_param_processor.sv
// Directed, table-driven bench for param_processor (WIDTH=16, NREGS=8).
// Register contents are observed through the bus by issuing mv R7,Rk.
module tb_param_processor;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        Run   = 1'b0;
    logic [15:0] DIN   = '0;
    logic        Done, W;
    logic [15:0] BUS, ADDR, DOUT;
`ifdef PROC_FLAGS_EN
    logic [2:0]  Flags;
`endif

    param_processor #(.WIDTH(16), .NREGS(8)) dut (
        .Clock(Clock),
        .Reset(Reset),
        .Run  (Run),
        .DIN  (DIN),
        .Done (Done),
        .BUS  (BUS),
        .ADDR (ADDR),
        .DOUT (DOUT),
`ifdef PROC_FLAGS_EN
        .Flags(Flags),
`endif
        .W    (W)
    );

    always #5 Clock = ~Clock;

    int nchecks = 0;
    int nerr    = 0;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] imm;   // DIN after the Run cycle (mvi immediate / ld data)
        int          lat;
        int          wcnt;
        logic [15:0] addr;
        logic [15:0] dout;
        logic [2:0]  rreg;
        logic [15:0] rval;
    } vec_t;

    vec_t tv [14];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {op, rx, ry, 7'b0};
    endfunction

    // Issue one instruction; report latency to Done, W-high cycles, and outputs in the Done cycle.
    task automatic exec(input logic [15:0] instr, input logic [15:0] imm, output int lat,
                        output logic [15:0] bus_d, output logic [15:0] addr_d,
                        output logic [15:0] dout_d, output int wcnt);
        lat = 1; wcnt = 0; bus_d = '0; addr_d = '0; dout_d = '0;
        @(negedge Clock); Run = 1'b1; DIN = instr;
        @(negedge Clock); Run = 1'b0; DIN = imm; #1;
        while (1) begin
            if (W) wcnt++;
            if (Done) begin
                bus_d = BUS; addr_d = ADDR; dout_d = DOUT;
                break;
            end
            if (lat >= 8) begin
                nchecks++; nerr++;
                $display("FAIL timeout: no Done for instr %h", instr);
                break;
            end
            @(negedge Clock); #1;
            lat++;
        end
    endtask

    task automatic rd(input logic [2:0] k, output logic [15:0] v);
        int l, wc;
        logic [15:0] a, d;
        exec(enc(3'b000, 3'd7, k), 16'h0, l, v, a, d, wc);
    endtask

    initial begin
        int          lat, wc;
        logic [15:0] b, a, d, v;

        tv[0]  = '{16'h2000, 16'h0005, 1, 0, 16'h0000, 16'h0000, 3'd0, 16'h0005}; // mvi R0,5
        tv[1]  = '{16'h0400, 16'h0000, 1, 0, 16'h0000, 16'h0000, 3'd1, 16'h0005}; // mv R1,R0
        tv[2]  = '{16'h4080, 16'h0000, 3, 0, 16'h0000, 16'h0000, 3'd0, 16'h000A}; // add R0,R1
        tv[3]  = '{16'h6400, 16'h0000, 3, 0, 16'h0000, 16'h0000, 3'd1, 16'hFFFB}; // sub R1,R0
        tv[4]  = '{16'h8800, 16'h1234, 3, 0, 16'h000A, 16'h0000, 3'd2, 16'h1234}; // ld R2,[R0]
        tv[5]  = '{16'hA880, 16'h0000, 2, 1, 16'hFFFB, 16'h1234, 3'd2, 16'h1234}; // st R2,[R1]
        tv[6]  = '{16'h3000, 16'h0007, 1, 0, 16'hFFFB, 16'h1234, 3'd4, 16'h0007}; // mvi R4,7
        tv[7]  = '{16'h7200, 16'h0000, 3, 0, 16'hFFFB, 16'h1234, 3'd4, 16'h0000}; // sub R4,R4 (Z=1)
        tv[8]  = '{16'h2C00, 16'h0055, 1, 0, 16'hFFFB, 16'h1234, 3'd3, 16'h0055}; // mvi R3,0x55
        tv[9]  = '{16'hCD00, 16'h0000, 1, 0, 16'hFFFB, 16'h1234, 3'd3, 16'h0055}; // mvnz R3,R2 blocked
        tv[10] = '{16'h4000, 16'h0000, 3, 0, 16'hFFFB, 16'h1234, 3'd0, 16'h0014}; // add R0,R0 (Z=0)
        tv[11] = '{16'hCD00, 16'h0000, 1, 0, 16'hFFFB, 16'h1234, 3'd3, 16'h1234}; // mvnz R3,R2 taken
        tv[12] = '{16'hE000, 16'h0000, 1, 0, 16'hFFFB, 16'h1234, 3'd0, 16'h0014}; // reserved
        tv[13] = '{16'hA000, 16'h0000, 2, 1, 16'h0014, 16'h0014, 3'd0, 16'h0014}; // st R0,[R0]

        // Reset state
        repeat (2) @(negedge Clock);
        #1;
        check("rst_done", Done, 1'b0);
        check("rst_w",    W,    1'b0);
        check("rst_bus",  BUS,  16'h0);
        check("rst_addr", ADDR, 16'h0);
        check("rst_dout", DOUT, 16'h0);
        @(negedge Clock); Reset = 1'b0;
        rd(3'd3, v);
        check("rst_r3", v, 16'h0);

        foreach (tv[i]) begin
            exec(tv[i].instr, tv[i].imm, lat, b, a, d, wc);
            check($sformatf("v%0d_lat", i),  lat, tv[i].lat);
            check($sformatf("v%0d_w", i),    wc,  tv[i].wcnt);
            check($sformatf("v%0d_addr", i), a,   tv[i].addr);
            check($sformatf("v%0d_dout", i), d,   tv[i].dout);
            rd(tv[i].rreg, v);
            check($sformatf("v%0d_reg", i),  v,   tv[i].rval);
        end

        // Reset pulsed during T2 of add R5,R5 aborts everything
        exec(enc(3'b001, 3'd5, 3'd0), 16'h0003, lat, b, a, d, wc);
        @(negedge Clock); Run = 1'b1; DIN = enc(3'b010, 3'd5, 3'd5);
        @(negedge Clock); Run = 1'b0; DIN = '0;
        @(negedge Clock); Reset = 1'b1; #1;
        check("mid_rst_done", Done, 1'b0);
        check("mid_rst_bus",  BUS,  16'h0);
        check("mid_rst_addr", ADDR, 16'h0);
        check("mid_rst_dout", DOUT, 16'h0);
        @(negedge Clock); Reset = 1'b0;
        rd(3'd5, v); check("mid_rst_r5", v, 16'h0);
        rd(3'd0, v); check("mid_rst_r0", v, 16'h0);

        // Run held high with a different word on DIN during T1..T3 must not reload IR
        exec(enc(3'b001, 3'd6, 3'd0), 16'h0002, lat, b, a, d, wc);
        @(negedge Clock); Run = 1'b1; DIN = 16'h5B00;             // add R6,R6
        @(negedge Clock); DIN = 16'h1800; #1;                     // mv R6,R0 offered
        lat = 1;
        while (!Done && lat < 8) begin
            @(negedge Clock); #1;
            lat++;
        end
        Run = 1'b0;
        check("hold_run_lat", lat, 3);
        @(negedge Clock); #1;
        check("hold_run_idle_done", Done, 1'b0);
        rd(3'd6, v); check("hold_run_r6", v, 16'h0004);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/param_processor.md
Name: param_processor

Overview:
- Next-generation multi-cycle processor core, parametrised in data width and register-file depth.
- Executes the full instruction set mv, mvi, add, sub, ld, st and mvnz, using a Run/Done handshake on the instruction port.
- Adds a data-memory port (ADDR/DOUT/W with DIN read-back) so ld/st reach external RAM.
- Sits between the instruction/data memory wrapper and the system top.

Parameters:
- WIDTH, 16, data/bus/instruction width; must satisfy WIDTH >= 3 + 2*RBITS.
- NREGS, 8, number of general registers; must be a power of two >= 2; RBITS = $clog2(NREGS).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Run  in  1  instruction word valid on DIN (sampled in IDLE only).
- DIN  in  WIDTH  instruction word, mvi immediate, or ld read data.
- Done  out  1  high for exactly the final cycle of each instruction.
- BUS  out  WIDTH  internal bus value (debug/observation).
- ADDR  out  WIDTH  data-memory address register.
- DOUT  out  WIDTH  data-memory write-data register.
- W  out  1  data-memory write strobe.

Behaviour:
- Encoding: opcode = IR[WIDTH-1 -: 3], Rx = next RBITS bits, Ry = next RBITS bits, remaining LSBs ignored.
- Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 100 ld, 101 st, 110 mvnz, 111 reserved.
- Reset: state IDLE; all Rk, IR, A, G, Z, ADDR, DOUT cleared to 0; Done=0, W=0, BUS=0.
- Reset asserted mid-instruction aborts the instruction; no partial register write survives.
- States: IDLE, T1, T2, T3. Every instruction returns to IDLE after its Done cycle.
- IDLE: if Run, IR<=DIN, go to T1. Run is ignored in any other state, with no queueing.
- Cycle-by-cycle execution:
  - mv: T1: BUS=Ry, Rx<=BUS, Done.
  - mvi: T1: the immediate word is on DIN; BUS=DIN, Rx<=BUS, Done.
  - add/sub: T1: A<=Rx. T2: G<=A+Ry or A-Ry (modulo 2^WIDTH, carry discarded), Z<=(result==0). T3: Rx<=G, Done.
  - ld: T1: ADDR<=Ry. T2: wait (1-cycle RAM read latency). T3: Rx<=DIN, Done.
  - st: T1: ADDR<=Ry, DOUT<=Rx. T2: W=1, Done.
  - mvnz: T1: if Z==0 then Rx<=Ry; Done in either case.
  - 111: T1: Done only; no state change.
- Z changes only in T2 of add/sub.
- Rx==Ry is legal for every opcode: add Rx,Rx doubles the value; st writes Rx to address Rx.
- Bus source priority: exactly one source is active per cycle. BUS=0 when none is selected (IDLE, waits).
- W is high only in st T2. ADDR and DOUT hold their values until the next ld/st.
- Done and W are combinational decodes of state and IR.
- Latency from the Run cycle to Done: 1 cycle for mv, mvi, mvnz, reserved; 2 for st; 3 for add, sub, ld.

Optional Feature:
- Macro PROC_FLAGS_EN.
- Defined:
  - Extra output Flags[2:0] = {Z, N, C}, registered in T2 of add/sub.
  - N = result MSB.
  - C = carry-out for add, NOT borrow for sub.
  - Flags resets to 0.
- Undefined: port and N/C registers absent; Z remains internal and mvnz behaviour is unchanged.

Decomposition:
- Package proc_pkg:
  - opcode_t enum (MV..RSVD, 3 bits).
  - state_t enum (IDLE, T1, T2, T3).
  - Opcode field-width constant (3).
- Sub-module proc_reg: WIDTH-parametrised, enable-loaded register with async active-high reset to 0.
- proc_reg is instantiated for IR, A, G, ADDR, DOUT and a generate array of NREGS registers.

Test Plan (WIDTH=16, NREGS=8; encoding opcode[15:13] Rx[12:10] Ry[9:7]):
- Reset, then Run with DIN=0x2000 and DIN=0x0005 in the next cycle (mvi R0,5) -> Done in T1, R0=0x0005. Then mv R1,R0 (0x0400) -> R1=0x0005, Done 1 cycle after Run.
- add R0,R1 (0x4080) -> Done exactly 3 cycles after Run, R0=0x000A, Z=0. Then sub R1,R0 (0x6400) -> R1=0xFFFB (wrap-around), Z=0.
- ld R2,[R0] (0x8800), with RAM returning DIN=0x1234 in T3 -> ADDR=0x000A from T2, R2=0x1234, Done in T3.
- st R2,[R1] (0xA880) -> in T2: W=1, ADDR=0xFFFB, DOUT=0x1234, Done=1; W=0 in every other cycle.
- mvnz R3,R2 after sub R4,R4 (Z=1) -> R3 unchanged. After an add giving a nonzero result -> R3=R2.
- Reset pulsed during T2 of add -> all registers 0, state IDLE, Done=0. Run held high during T1/T2 -> no second IR load before IDLE.
